capture_receiver_of_verifla: RTL

Host-end counterpart of the VeriFLA capture path. It issues the one-byte run command to a remote logic analyzer through a UART transmitter, then collects the returned capture byte stream from a UART receiver. It reassembles the bytes into memory words and writes them, in order, to a local dual-port capture memory. It sits between the UART of a second FPGA (or a loopback bench) and a local memory_of_verifla-style buffer, and gives the verification bench and on-chip consumers a bit-accurate copy of the remote capture.

---
 rtl/capture_receiver_of_verifla.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/capture_receiver_of_verifla.sv
// capture_receiver_of_verifla
//   Host-end side of the VeriFLA capture path. Sends the run command byte to a
//   remote analyzer through a UART transmitter, then reassembles the returned
//   byte stream (most-significant byte first) into capture words and writes
//   them in order to a local dual-port capture memory (port A).
//
// Ports
//   clk, rst          : single clock, synchronous active-high reset
//   start             : one-cycle request to begin a run/collect cycle
//   busy              : high from accepted start until return to idle
//   done              : one-cycle pulse at the end of every transfer
//   timeout_err       : sticky abort flag, cleared by the next accepted start
//   words_rcvd        : words written in the current/last transfer
//   xmitH, xmit_dataH : load strobe and byte for the UART transmitter
//   xmit_doneH        : transmitter finished its byte
//   rec_dataH, rec_readyH : received byte and its one-cycle strobe
//   mem_wea, mem_addra, mem_dina : capture memory write port
module capture_receiver_of_verifla #(
    parameter int unsigned WORD_BYTES     = 4,
    parameter int unsigned ADDR_BITS      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  RUN_CMD        = 8'h01
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout_err,
    output logic [ADDR_BITS:0]      words_rcvd,
    output logic                    xmitH,
    output logic [7:0]              xmit_dataH,
    input  logic                    xmit_doneH,
    input  logic [7:0]              rec_dataH,
    input  logic                    rec_readyH,
    output logic                    mem_wea,
    output logic [ADDR_BITS-1:0]    mem_addra,
    output logic [8*WORD_BYTES-1:0] mem_dina
);

    localparam int unsigned WORD_W = 8 * WORD_BYTES;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_TX,
        RECV,
        FINISH
    } state_t;

    state_t state, state_next;

    logic [WORD_W-1:0] asm_q;
    logic [WORD_W-1:0] asm_shift;
    logic [IDX_W-1:0]  byte_idx;
    logic [CNT_W-1:0]  to_cnt;

    logic active;
    logic last_write;
    logic accept;
    logic last_byte;
    logic cnt_clear;
    logic expire;

    logic busy_d;
    logic done_d;
    logic xmit_d;

    assign active     = (state == WAIT_TX) || (state == RECV);
    // Final word of the transfer is on the memory port this cycle.
    assign last_write = mem_wea && (mem_addra == '1);
    // Bytes arriving alongside the final write belong to no word and are dropped.
    assign accept     = rec_readyH && active && !last_write;
    assign last_byte  = (byte_idx == IDX_W'(WORD_BYTES - 1));
    assign asm_shift  = (asm_q << 8) | WORD_W'(rec_dataH);
    assign cnt_clear  = rec_readyH || ((state == WAIT_TX) && xmit_doneH);
    // Counter would reach TIMEOUT_CYCLES this cycle; a byte in the same cycle wins.
    assign expire     = active && !cnt_clear && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = SEND;
            SEND:    state_next = WAIT_TX;
            WAIT_TX: begin
                if (expire)          state_next = FINISH;
                else if (xmit_doneH) state_next = RECV;
            end
            RECV: begin
                if (last_write || expire) state_next = FINISH;
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode; decoded from the next state so the registered copies line
    // up with the state they belong to.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        xmit_d = 1'b0;
        unique case (state_next)
            SEND:    begin busy_d = 1'b1; xmit_d = 1'b1; end
            WAIT_TX: busy_d = 1'b1;
            RECV:    busy_d = 1'b1;
            FINISH:  done_d = 1'b1;
            default: ;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            xmitH       <= 1'b0;
            xmit_dataH  <= '0;
            timeout_err <= 1'b0;
            words_rcvd  <= '0;
            mem_wea     <= 1'b0;
            mem_addra   <= '0;
            mem_dina    <= '0;
            asm_q       <= '0;
            byte_idx    <= '0;
            to_cnt      <= '0;
        end else begin
            busy       <= busy_d;
            done       <= done_d;
            xmitH      <= xmit_d;
            xmit_dataH <= xmit_d ? RUN_CMD : 8'h00;
            mem_wea    <= 1'b0;

            if ((state == IDLE) && start) begin
                timeout_err <= 1'b0;
                words_rcvd  <= '0;
                mem_addra   <= '0;
                asm_q       <= '0;
                byte_idx    <= '0;
                to_cnt      <= '0;
            end else begin
                // Address/count advance the cycle after the write strobe so the
                // write itself presents the pre-increment address.
                if (mem_wea) begin
                    mem_addra  <= mem_addra + 1'b1;
                    words_rcvd <= words_rcvd + 1'b1;
                end

                if (accept) begin
                    if (last_byte) begin
                        mem_wea  <= 1'b1;
                        mem_dina <= asm_shift;
                        asm_q    <= '0;
                        byte_idx <= '0;
                    end else begin
                        asm_q    <= asm_shift;
                        byte_idx <= byte_idx + IDX_W'(1);
                    end
                end

                if (active) begin
                    if (cnt_clear) to_cnt <= '0;
                    else           to_cnt <= to_cnt + CNT_W'(1);
                end

                if (expire) begin
                    timeout_err <= 1'b1;
                    byte_idx    <= '0;
                    asm_q       <= '0;
                end
            end
        end
    end

endmodule
